rx_byte_fifo: RTL and testbench
===============================

# rx_byte_fifo

Receive-side byte buffer between `uart_rx` and the application controller (password/query FSM). It turns the receiver's level-style `data_ready`/`data`/`comm_err` outputs into one push per received byte. Bytes and their framing-error tags are stored in a first-word-fall-through FIFO, so the controller can pop them at its own pace without losing characters while it is busy transmitting. Overflow is reported with a sticky flag.

## Interface

**Parameters**
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `WIDTH`, 8: data byte width.

**Ports**
- `clk`, in, 1: system clock (27 MHz).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, WIDTH: byte from `uart_rx`. Stable while `rx_ready` is high.
- `rx_ready`, in, 1: `uart_rx` data-ready level.
- `rx_err`, in, 1: `uart_rx` comm_err. Sampled together with `rx_data`.
- `rd_en`, in, 1: pop request from the consumer.
- `rd_data`, out, WIDTH: head byte. Valid whenever `empty` = 0.
- `rd_err`, out, 1: framing-error tag of the head byte.
- `empty`, out, 1: FIFO holds no entries.
- `full`, out, 1: FIFO holds DEPTH entries.
- `count`, out, $clog2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky; set when a byte is dropped.
- `clr_ovf`, in, 1: synchronous clear of `overflow`.

## Operation

- **Push detect.** `rdy_d` registers `rx_ready` every cycle and resets to 1. `push = rx_ready & ~rdy_d`, so each rising edge of `rx_ready` gives one push. If `rx_ready` is already high when reset releases, no push occurs.
- **Entry contents.** Each entry is {`rx_err`, `rx_data`}, WIDTH+1 bits, stored in a register array.
- **Pointers.** `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
  - `count` = `wr_ptr - rd_ptr`, modulo 2^($clog2(DEPTH)+1).
  - Pointers wrap naturally with no special case.
- **Pop.** Effective pop = `rd_en & ~empty`. `rd_en` while empty is ignored: no pointer change, no error.
- **Push while full, no pop that cycle.** The byte is dropped, `overflow` is set, and the pointers are unchanged.
- **Push and pop in the same cycle while full.** Both take effect: no drop, `count` stays at DEPTH.
- **Push and pop in the same cycle while empty.** Only the push takes effect; the pop is ignored.
- **Push and pop in the same cycle otherwise.** Both take effect and `count` is unchanged.
- **Overflow clearing.** `clr_ovf` clears `overflow`. If a drop and `clr_ovf` occur in the same cycle, the set wins.
- **Head outputs.** `rd_data` and `rd_err` are driven combinationally from the entry at `rd_ptr` (FWFT). When the FIFO is empty they hold the value of the stale slot; they are don't-care.

## Timing

- **Reset values.** Pointers 0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `rdy_d`=1. Array contents are not reset. `rd_data`/`rd_err` are undefined while `empty`.
- **Reset mid-operation.** All stored bytes are discarded immediately (asynchronous). After release, a push needs a fresh rising edge of `rx_ready`.
- **Push latency.** A byte is written on the first clock edge at which `rx_ready`=1 and `rdy_d`=0. After that edge, `empty` falls, `count` increments, and `rd_data` shows the byte if it is the new head. Edge-to-visible is therefore 1 cycle.
- **Pop latency.** On the edge where a pop takes effect, `rd_ptr` advances and the next entry appears on `rd_data` in the following cycle. Sustained throughput is 1 pop per cycle.
- **Flag timing.** All flags are registered-pointer derived, with no combinational path from `rd_en` to the flags.
- **Input rate.** At 9600 baud, pushes are at least 2812 cycles apart. The block still accepts a push on every cycle for test purposes.

## Structure

- **Shared package.** The `uart_pkg` parameters `DELAY_FRAMES`, `BIT_PER_WORD`, and the default `RX_FIFO_DEPTH`=16 belong here, next to `TX_BUFFER_SIZE`.
- **Sub-module.** One natural sub-module, `edge_pulse`: a rising-edge detector with a reset-to-1 delay register. It is reusable for `btn` click detection in the controller.
- **Storage.** The storage array and pointer logic stay inline.

## Test plan

- **Reset with input high.** Hold `rx_ready`=1 across reset release → no push, `empty`=1, `count`=0. Drop to 0, raise again with `rx_data`=0x31 → `empty`=0, `rd_data`=0x31, `rd_err`=0.
- **Ordering and wrap.** Push "1","a","2","B", then pop 4 times → `rd_data` sequence 0x31, 0x61, 0x32, 0x42, then `empty`=1. Repeat 5 times (20 bytes, DEPTH=16) → pointers wrap and order is preserved.
- **Overflow.** Fill with 16 bytes, then push 0x7E with `rd_en`=0 → `full`=1, `count`=16, `overflow`=1, head is still byte 0. Pulse `clr_ovf` → `overflow`=0.
- **Full boundary, simultaneous push/pop.** Full FIFO, push 0x55 and pop in the same cycle → `count`=16, `overflow`=0, and 0x55 is popped last.
- **Empty boundary.** Empty FIFO, assert `rd_en`, then push 0x20 with `rd_en`=1 in the same cycle → `count`=1, `rd_data`=0x20 next cycle.
- **Error tag and mid-operation reset.** Push 0x41 with `rx_err`=1 → `rd_err`=1 for that entry only. With 3 entries stored, assert `rst_n`=0 for one cycle → `empty`=1 and `count`=0 immediately.

Source files
------------

// File: rtl/rx_byte_fifo_pkg.sv
// Shared UART/receive-path constants: bit timing, word size and buffer depths.
package rx_byte_fifo_pkg;

  localparam int CLK_HZ         = 27_000_000;
  localparam int BAUD_RATE      = 9600;
  localparam int DELAY_FRAMES   = CLK_HZ / BAUD_RATE;
  localparam int BIT_PER_WORD   = 8;
  localparam int RX_FIFO_DEPTH  = 16;
  localparam int TX_BUFFER_SIZE = 8;

  // Pointer width including the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_byte_fifo_if.sv
// Receive FIFO bus: uart_rx-side push inputs and consumer-side FWFT pop outputs.
// rx_ready is a level; each rising edge pushes {rx_err, rx_data} once. The head
// (rd_data/rd_err) is valid whenever empty=0 and rd_en pops it on the clock edge.
interface rx_byte_fifo_if
  import rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int WIDTH = BIT_PER_WORD
);

  logic [WIDTH-1:0]            rx_data;
  logic                        rx_ready;
  logic                        rx_err;
  logic                        rd_en;
  logic                        clr_ovf;
  logic [WIDTH-1:0]            rd_data;
  logic                        rd_err;
  logic                        empty;
  logic                        full;
  logic [ptr_width(DEPTH)-1:0] count;
  logic                        overflow;

  modport master (
    output rx_data, rx_ready, rx_err, rd_en, clr_ovf,
    input  rd_data, rd_err, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_ready, rx_err, rd_en, clr_ovf,
    output rd_data, rd_err, empty, full, count, overflow
  );

endinterface

// File: rtl/rx_byte_fifo_edge_pulse.sv
// Rising-edge detector; the delay register resets to 1 so a level already high
// at reset release does not produce a pulse.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b1;
    else        level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO between uart_rx and the application
// controller; stores each byte with its framing-error tag, sticky overflow.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int WIDTH = BIT_PER_WORD
) (
  input logic           clk,
  input logic           rst_n,
  rx_byte_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            push;
  logic            empty, full;
  logic            do_pop, do_push, drop;

  edge_pulse u_rx_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (bus.rx_ready),
    .pulse_o (push)
  );

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop on the same edge frees the slot, so a push into a full FIFO survives.
  assign do_pop  = bus.rd_en & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_push)          wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)           rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop)             ovf_d    = 1'b1;
    else if (bus.clr_ovf) ovf_d    = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.rx_err, bus.rx_data};
  end

  assign {bus.rd_err, bus.rd_data} = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: directed boundary cases plus random traffic against a
// queue-based reference model; a negedge monitor compares flags and head.
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rx_byte_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  rx_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model state
  logic [WIDTH:0] exp_q[$];
  bit             m_ovf;
  bit             m_prev;
  bit             m_push, m_pop, m_full, m_drop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: evaluates the edge just taken using the inputs held across it.
  initial begin
    m_prev = 1'b1;
    m_ovf  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        exp_q.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b1;
      end else begin
        m_push = bus.rx_ready && !m_prev;
        m_prev = bus.rx_ready;
        m_pop  = bus.rd_en && (exp_q.size() != 0);
        m_full = (exp_q.size() == DEPTH);
        m_drop = m_push && m_full && !m_pop;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push && !m_drop) exp_q.push_back({bus.rx_err, bus.rx_data});
        if (m_drop)             m_ovf = 1'b1;
        else if (bus.clr_ovf)   m_ovf = 1'b0;
      end
    end
  end

  // Monitor: outputs are register-derived, so negedge sampling is stable.
  initial begin
    forever begin
      @(negedge clk);
      check("empty", bus.empty, exp_q.size() == 0);
      check("full", bus.full, exp_q.size() == DEPTH);
      check("count", bus.count, exp_q.size());
      check("overflow", bus.overflow, m_ovf);
      if (exp_q.size() != 0) begin
        check("head_data", bus.rd_data, exp_q[0][WIDTH-1:0]);
        check("head_err", bus.rd_err, exp_q[0][WIDTH]);
      end
    end
  end

  task automatic drive(input bit rdy, input logic [7:0] d, input bit e, input bit rd, input bit clr);
    @(negedge clk);
    bus.rx_ready = rdy;
    bus.rx_data  = d;
    bus.rx_err   = e;
    bus.rd_en    = rd;
    bus.clr_ovf  = clr;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit e, input bit rd);
    drive(1'b1, d, e, rd, 1'b0);
    drive(1'b0, d, e, 1'b0, 1'b0);
  endtask

  task automatic pop_n(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
    #1;
    check("rst_empty", bus.empty, 1);
    check("rst_count", bus.count, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [7:0] pat [4];
  logic [7:0] cur_data;
  bit         rdy, rd, clr;

  initial begin
    rst_n        = 1'b0;
    bus.rx_ready = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_err   = 1'b0;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    pat = '{8'h31, 8'h61, 8'h32, 8'h42};

    // Reset released with rx_ready already high: no push
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check("hold_empty", bus.empty, 1);
    check("hold_count", bus.count, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push_byte(8'h31, 1'b0, 1'b0);
    check("first_empty", bus.empty, 0);
    check("first_data", bus.rd_data, 8'h31);
    check("first_err", bus.rd_err, 0);
    pop_n(1);

    // Ordering and pointer wrap
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) push_byte(pat[i], 1'b0, 1'b0);
      check("order_count", bus.count, 4);
      pop_n(4);
      check("order_empty", bus.empty, 1);
    end

    // Overflow, clear, and drop-vs-clear priority
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    push_byte(8'h7E, 1'b0, 1'b0);
    check("ovf_full", bus.full, 1);
    check("ovf_count", bus.count, 16);
    check("ovf_flag", bus.overflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("ovf_cleared", bus.overflow, 0);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h99, 1'b0, 1'b0, 1'b0);
    check("ovf_set_wins", bus.overflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Full boundary: push and pop on the same edge
    push_byte(8'h55, 1'b0, 1'b1);
    check("fullpp_count", bus.count, 16);
    check("fullpp_ovf", bus.overflow, 0);
    pop_n(15);
    check("fullpp_last", bus.rd_data, 8'h55);
    pop_n(1);
    check("fullpp_empty", bus.empty, 1);

    // Empty boundary: pop request on empty, then push with pop held
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
    check("emptypp_count", bus.count, 1);
    check("emptypp_data", bus.rd_data, 8'h20);
    pop_n(1);

    // Error tag follows only its own entry
    push_byte(8'h41, 1'b1, 1'b0);
    push_byte(8'h42, 1'b0, 1'b0);
    check("err_tag", bus.rd_err, 1);
    pop_n(1);
    check("err_next", bus.rd_err, 0);
    check("err_next_data", bus.rd_data, 8'h42);
    pop_n(1);

    // Mid-operation reset discards stored bytes
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i), 1'b0, 1'b0);
    check("pre_rst_count", bus.count, 3);
    reset_pulse();
    idle(2);
    check("post_rst_empty", bus.empty, 1);

    // Random traffic: fill-biased then drain-biased phases
    cur_data = 8'h00;
    for (int ph = 0; ph < 2; ph++) begin
      repeat (700) begin
        rdy = ($urandom_range(0, 2) != 0);
        if (!bus.rx_ready) cur_data = 8'($urandom_range(0, 255));
        rd  = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 40) == 0);
        drive(rdy, cur_data, (bus.rx_ready ? bus.rx_err : 1'($urandom_range(0, 1))), rd, clr);
      end
    end
    pop_n(DEPTH + 1);
    check("final_empty", bus.empty, 1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
